// File: rtl/des_result_serializer.sv
// Buffers 64-bit DES result blocks and drains them as 16-bit words, word 0 (bits 15:0) first.
// Latency 1 from accept to ep_datain when empty; blk_ready drops only on a full buffer, from registered state alone.
module des_result_serializer #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          ti_clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          blk_valid,
    input  logic [63:0]   blk_data,
    output logic          blk_ready,
    input  logic          ep_read,
    output logic [15:0]   ep_datain,
    output logic [CW-1:0] blk_count,
    output logic          underflow,
    output logic          drained
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    wsel;
    logic          empty;
    logic          accept;
    logic          rd_en;
    logic          pop;
    logic [63:0]   head;

    assign empty     = (blk_count == '0);
    assign blk_ready = (blk_count != FULL);
    // clear wins over everything, so an offered block is dropped rather than stored
    assign accept    = blk_valid && blk_ready && !clear;
    assign rd_en     = ep_read && !empty && !clear;
    assign pop       = rd_en && (wsel == 2'd3);

    always_ff @(posedge ti_clk) begin
        if (accept) begin
            mem[wr_ptr] <= blk_data;
        end
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wsel      <= 2'd0;
            blk_count <= '0;
            underflow <= 1'b0;
            drained   <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wsel      <= 2'd0;
            blk_count <= '0;
            underflow <= 1'b0;
            drained   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                if (wsel == 2'd3) begin
                    wsel   <= 2'd0;
                    rd_ptr <= rd_ptr + AW'(1);
                end else begin
                    wsel <= wsel + 2'd1;
                end
            end
            case ({accept, pop})
                2'b10:   blk_count <= blk_count + CW'(1);
                2'b01:   blk_count <= blk_count - CW'(1);
                default: blk_count <= blk_count;
            endcase
            if (ep_read && empty) begin
                underflow <= 1'b1;
            end
            drained <= pop && (blk_count == CW'(1)) && !accept;
        end
    end

    always_comb begin
        head      = mem[rd_ptr];
        ep_datain = 16'h0000;
        if (!empty) begin
            case (wsel)
                2'd0:    ep_datain = head[15:0];
                2'd1:    ep_datain = head[31:16];
                2'd2:    ep_datain = head[47:32];
                default: ep_datain = head[63:48];
            endcase
        end
    end

endmodule

// File: doc/des_result_serializer.md
DES_RESULT_SERIALIZER -- requirements
Module: des_result_serializer

Purpose: buffers 64-bit DES result blocks from the block engine and drains them to a 16-bit PipeOut endpoint. The block engine is the writer; the host pipe is the reader.

Interface
REQ-001 Parameter DEPTH, default 4: number of 64-bit block slots; SHALL be a power of 2 and at least 2.
REQ-002 ti_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous flush; a single-cycle trigger-derived strobe.
REQ-005 blk_valid  input  1  the block engine offers blk_data this cycle.
REQ-006 blk_data  input  64  result block; bits 15:0 are word 0 and bits 63:48 are word 3.
REQ-007 blk_ready  output  1  a slot is free; a block is accepted when blk_valid and blk_ready are both high.
REQ-008 ep_read  input  1  PipeOut read strobe; one 16-bit word is consumed per high cycle.
REQ-009 ep_datain  output  16  word currently presented to the pipe.
REQ-010 blk_count  output  log2(DEPTH)+1  number of stored blocks, including a partially read head block.
REQ-011 underflow  output  1  sticky flag: a read was attempted while the buffer was empty.
REQ-012 drained  output  1  one-cycle pulse when the final word of the final stored block is consumed.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH x 64 bits with write pointer wr_ptr, read pointer rd_ptr and a 2-bit word selector wsel.
REQ-014 blk_ready SHALL equal (blk_count != DEPTH), derived from registered state only, with no combinational path from ep_read.
REQ-015 On accept: store blk_data at wr_ptr, increment wr_ptr modulo DEPTH, increment blk_count.
REQ-016 ep_datain SHALL be combinational: word wsel of the block at rd_ptr when blk_count != 0, otherwise 16'h0000.
REQ-017 A block accepted into an empty buffer SHALL appear on ep_datain in the cycle after acceptance (latency 1).
REQ-018 On ep_read with blk_count != 0 and wsel < 3: increment wsel.
REQ-019 On ep_read with blk_count != 0 and wsel == 3: set wsel to 0, increment rd_ptr modulo DEPTH, decrement blk_count (pop).
REQ-020 On ep_read with blk_count == 0: set underflow to 1; pointers, wsel and blk_count are unchanged.
REQ-021 Accept and pop in the same cycle: both take effect and blk_count is unchanged.
REQ-022 When full, an accept is impossible even if a pop occurs in the same cycle, because blk_ready was already low.
REQ-023 Pointers SHALL wrap with no gap: after DEPTH accepts and DEPTH pops, both pointers return to 0.
REQ-024 drained SHALL be a registered pulse, high for exactly one cycle following a pop that leaves blk_count == 0 with no simultaneous accept.
REQ-025 clear SHALL have priority over accept, pop and underflow in the same cycle.
REQ-026 clear SHALL zero wr_ptr, rd_ptr, wsel, blk_count, underflow and drained, and SHALL drop any block offered in that cycle.
REQ-027 clear asserted mid-block SHALL discard the remaining words of the head block.
REQ-028 Storage contents need not be cleared on clear or reset; an empty buffer still outputs 16'h0000.

Reset
REQ-029 While reset is high, asynchronously: wr_ptr=0, rd_ptr=0, wsel=0, blk_count=0, underflow=0, drained=0.
REQ-030 Consequently, during and after reset: blk_ready=1 and ep_datain=16'h0000.
REQ-031 Reset mid-operation SHALL abandon all stored blocks and any partially read word sequence.
REQ-032 The first accept is permitted on the first rising edge after reset deasserts.

Verification
REQ-033 Single block: accept 64'h0123_4567_89AB_CDEF, then 4 consecutive reads -> ep_datain sequence CDEF, 89AB, 4567, 0123; blk_count goes 1 then 0; drained high for one cycle after the 4th read.
REQ-034 Fill: 4 accepts with no reads (DEPTH=4) -> blk_ready=0 and blk_count=4. A 5th block offered is not stored. After 16 reads, words match blocks 1-4 in order.
REQ-035 Concurrent: buffer holds 1 block, wsel=3; ep_read and an accept in the same cycle -> blk_count stays 1; the next word is word 0 of the new block; drained stays 0.
REQ-036 Underflow: ep_read while empty -> ep_datain=0000, underflow=1 and held; a subsequent clear -> underflow=0.
REQ-037 Mid-block clear: accept 2 blocks, 2 reads, then clear -> blk_count=0 and ep_datain=0000; a new block then reads out starting at its word 0.
REQ-038 Wrap and reset: 9 accept/drain cycles of distinct blocks -> pointer wrap produces no data loss. Asynchronous reset asserted between clock edges -> outputs reach their reset values immediately, without waiting for a clock edge.
